// File: rtl/multiword_add_sequencer.sv
// Streams multi-word add/sub packets through an external 16-bit split-capable adder,
// chaining carries between beats. Define SIGNED_OVF_EN to add the out_ovf port.
module multiword_add_sequencer #(
    parameter int MAX_WORDS = 8,
    localparam int CNT_W = $clog2(MAX_WORDS + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_last,
    input  logic        in_split,
    input  logic        in_sub,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_ci,
    output logic        add_split,
    input  logic [15:0] add_s,
    input  logic        add_co,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_s,
    output logic        out_last,
    output logic        out_co,
    output logic        out_err
`ifdef SIGNED_OVF_EN
    ,
    output logic        out_ovf
`endif
);

    typedef enum logic [1:0] {IDLE, CHAIN, DRAIN} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] count, count_next;
    logic             carry_q, carry_next;
    logic             split_q, sub_q;
    logic             latch_mode;
    logic             first, accept, truncate, emit;
    logic             split_eff, sub_eff;

    assign first     = (state == IDLE);
    assign in_ready  = (state == DRAIN) | ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;
    assign emit      = accept & (state != DRAIN);
    assign truncate  = (count == LAST_CNT) & ~in_last;

    // Subtraction is meaningless across independent lanes, so split mode forces add.
    assign split_eff = first ? in_split : split_q;
    assign sub_eff   = first ? (in_sub & ~in_split) : sub_q;

    assign add_a     = in_a;
    assign add_b     = in_b ^ {16{sub_eff}};
    assign add_split = split_eff;
    assign add_ci    = (first | split_eff) ? sub_eff : carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            carry_q <= 1'b0;
            split_q <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            carry_q <= carry_next;
            if (latch_mode) begin
                split_q <= in_split;
                sub_q   <= in_sub & ~in_split;
            end
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        carry_next = carry_q;
        latch_mode = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (in_last | truncate) begin
                        count_next = '0;
                        carry_next = 1'b0;
                    end else begin
                        state_next = CHAIN;
                        count_next = CNT_W'(1);
                        carry_next = add_co;
                        latch_mode = 1'b1;
                    end
                end
                CHAIN: begin
                    if (in_last) begin
                        state_next = IDLE;
                        count_next = '0;
                        carry_next = 1'b0;
                    end else if (truncate) begin
                        state_next = DRAIN;
                        count_next = '0;
                        carry_next = 1'b0;
                    end else begin
                        count_next = count + CNT_W'(1);
                        carry_next = add_co;
                    end
                end
                DRAIN: begin
                    if (in_last) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // The output register only advances when a beat is emitted; otherwise it holds until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_s     <= 16'h0000;
            out_last  <= 1'b0;
            out_co    <= 1'b0;
            out_err   <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_s     <= add_s;
            out_co    <= add_co;
            out_last  <= in_last | truncate;
            out_err   <= truncate;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef SIGNED_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf <= 1'b0;
        end else if (emit) begin
            out_ovf <= (in_last | truncate) & ~split_eff & (in_a[15] == add_b[15]) &
                       (add_s[15] != in_a[15]);
        end
    end
`endif

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer: table vectors, hand sequences and
// randomized packets against a word-level arithmetic model. Honours SIGNED_OVF_EN.
module tb_multiword_add_sequencer;

    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic        in_last, in_split, in_sub;
    logic [15:0] add_a, add_b, add_s;
    logic        add_ci, add_split, add_co;
    logic        out_valid, out_ready;
    logic [15:0] out_s;
    logic        out_last, out_co, out_err;
`ifdef SIGNED_OVF_EN
    logic        out_ovf;
`endif

    int checks = 0;
    int failures = 0;

    multiword_add_sequencer #(.MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .in_split(in_split), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_split(add_split),
        .add_s(add_s), .add_co(add_co),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s(out_s), .out_last(out_last), .out_co(out_co), .out_err(out_err)
`ifdef SIGNED_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural split-capable adder: lane 0 takes Ci, lane 1 is isolated in split mode.
    logic [8:0] lane_lo, lane_hi;
    always_comb begin
        lane_lo = {1'b0, add_a[7:0]} + {1'b0, add_b[7:0]} + {8'd0, add_ci};
        lane_hi = {1'b0, add_a[15:8]} + {1'b0, add_b[15:8]} +
                  {8'd0, (add_split ? 1'b0 : lane_lo[8])};
        add_s   = {lane_hi[7:0], lane_lo[7:0]};
        add_co  = lane_hi[8];
    end

    typedef struct {
        logic [15:0] s;
        logic        last;
        logic        co;
        logic        err;
        logic        ovf;
    } outrec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        split;
        logic        sub;
        logic [15:0] exp_addb;
        logic        exp_ci;
        logic [15:0] exp_s;
        logic        exp_co;
        logic        exp_ovf;
    } vec_t;

    outrec_t     exp_q[$];
    logic [15:0] pa[16];
    logic [15:0] pb[16];
    int          plen;
    logic        psplit, psub;
    logic        mon_en = 1'b0;
    logic        rand_ready = 1'b0;
    logic        use_gaps = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] actPack();
        logic ovf;
`ifdef SIGNED_OVF_EN
        ovf = out_ovf;
`else
        ovf = 1'b0;
`endif
        return {12'd0, ovf, out_err, out_co, out_last, out_s};
    endfunction

    function automatic logic [31:0] expPack(input outrec_t r);
        logic ovf;
`ifdef SIGNED_OVF_EN
        ovf = r.ovf;
`else
        ovf = 1'b0;
`endif
        return {12'd0, ovf, r.err, r.co, r.last, r.s};
    endfunction

    // Reference: multi-precision A+B or A-B (A + ~B + 1) word by word, or two 8-bit lane sums.
    task automatic modelPacket();
        logic        carry, sub_e;
        logic [15:0] bb;
        logic [16:0] sum;
        logic [8:0]  lo9, hi9;
        outrec_t     r;
        int          nout;
        sub_e = psub & ~psplit;
        carry = sub_e;
        nout  = (plen > MAXW) ? MAXW : plen;
        for (int i = 0; i < nout; i++) begin
            bb = sub_e ? ~pb[i] : pb[i];
            if (psplit) begin
                lo9  = {1'b0, pa[i][7:0]} + {1'b0, bb[7:0]};
                hi9  = {1'b0, pa[i][15:8]} + {1'b0, bb[15:8]};
                r.s  = {hi9[7:0], lo9[7:0]};
                r.co = hi9[8];
            end else begin
                sum   = {1'b0, pa[i]} + {1'b0, bb} + {16'd0, carry};
                r.s   = sum[15:0];
                r.co  = sum[16];
                carry = sum[16];
            end
            r.last = (i == nout - 1);
            r.err  = r.last && (plen > MAXW);
            r.ovf  = r.last && !psplit && (pa[i][15] == bb[15]) && (r.s[15] != pa[i][15]);
            exp_q.push_back(r);
        end
    endtask

    task automatic sendBeat(input logic [15:0] a, input logic [15:0] b, input logic last,
                            input logic split, input logic sub);
        int  cyc = 0;
        logic done = 1'b0;
        in_a = a; in_b = b; in_last = last; in_split = split; in_sub = sub;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (!done && cyc > 200) begin
                checkOutput("accept_timeout", 32'(cyc), 32'(0));
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < plen; i++) begin
            if (use_gaps && ($urandom_range(0, 3) == 0)) begin
                @(posedge clk);
                #1;
            end
            if (i == 0)
                sendBeat(pa[i], pb[i], (plen == 1), psplit, psub);
            else
                sendBeat(pa[i], pb[i], (i == plen - 1), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
        end
    endtask

    task automatic waitEmpty();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("drain_pending", 32'(exp_q.size()), 32'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic randomPacket(input int len, input logic split, input logic sub);
        plen = len; psplit = split; psub = sub;
        for (int i = 0; i < len; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = 16'($urandom);
        end
        modelPacket();
        applyStimulus();
    endtask

    // Output monitor: scoreboard on every handshake, plus stability while stalled.
    initial begin
        logic    stalled = 1'b0;
        logic [31:0] held = '0;
        outrec_t r;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                if (stalled) begin
                    checkOutput("stall_valid", 32'(out_valid), 32'(1));
                    checkOutput("stall_hold", actPack(), held);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_out: got s=%h with no word expected", out_s);
                    end else begin
                        r = exp_q.pop_front();
                        checkOutput("out_word", actPack(), expPack(r));
                    end
                end
                stalled = out_valid && !out_ready;
                held    = actPack();
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        outrec_t r;
        vecs[0] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFF8, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[1] = '{16'h80FF, 16'h8001, 1'b1, 1'b1, 16'h8001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'hFFFA, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[5] = '{16'h7F7F, 16'h0101, 1'b1, 1'b0, 16'h0101, 1'b0, 16'h8080, 1'b0, 1'b0};
        vecs[6] = '{16'hFF01, 16'h01FF, 1'b1, 1'b0, 16'h01FF, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'hFFFE, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_last = 1'b0; in_split = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out", 32'({out_valid, out_last, out_co, out_err, out_s}), 32'(0));
        checkOutput("reset_in_ready", 32'(in_ready), 32'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-word packets: adder drive and registered result.
        for (int i = 0; i < 8; i++) begin
            in_a = vecs[i].a; in_b = vecs[i].b; in_split = vecs[i].split; in_sub = vecs[i].sub;
            in_last = 1'b1; in_valid = 1'b1;
            #1;
            checkOutput($sformatf("vec%0d_adder_drive", i),
                        32'({add_split, add_ci, add_a, add_b}),
                        32'({vecs[i].split, vecs[i].exp_ci, vecs[i].a, vecs[i].exp_addb}));
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            r = '{vecs[i].exp_s, 1'b1, vecs[i].exp_co, 1'b0, vecs[i].exp_ovf};
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(1));
            checkOutput($sformatf("vec%0d_result", i), actPack(), expPack(r));
        end
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Two-word add with carry across the word boundary.
        exp_q.push_back('{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0});
        exp_q.push_back('{16'h0002, 1'b1, 1'b0, 1'b0, 1'b0});
        sendBeat(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        sendBeat(16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitEmpty();

        // Over-long packet is cut at MAX_WORDS; exact-length and follow-up packets are normal.
        randomPacket(10, 1'b0, 1'b0);
        randomPacket(3, 1'b0, 1'b1);
        randomPacket(MAXW, 1'b0, 1'b1);
        randomPacket(MAXW + 1, 1'b1, 1'b0);
        waitEmpty();

        // Output stall for three cycles mid-packet with the input held valid.
        plen = 5; psplit = 1'b0; psub = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pa[i] = 16'($urandom);
            pb[i] = 16'($urandom);
        end
        modelPacket();
        fork
            applyStimulus();
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", 32'(in_ready), 32'(0));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        waitEmpty();

        // Reset mid-packet: first beat afterwards must start a fresh packet.
        mon_en = 1'b0;
        sendBeat(16'h1234, 16'h0001, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out", 32'({out_valid, out_last, out_co, out_err, out_s}), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        exp_q.push_back('{16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0});
        in_a = 16'h0005; in_b = 16'h0007; in_split = 1'b0; in_sub = 1'b1; in_last = 1'b0;
        in_valid = 1'b1;
        #1;
        checkOutput("fresh_first_beat", 32'({add_split, add_ci, add_b}), 32'({1'b0, 1'b1, 16'hFFF8}));
        sendBeat(16'h0005, 16'h0007, 1'b0, 1'b0, 1'b1);
        sendBeat(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        waitEmpty();

        // Randomized packets with back-pressure and input gaps.
        rand_ready = 1'b1;
        use_gaps = 1'b1;
        for (int p = 0; p < 40; p++) begin
            randomPacket($urandom_range(1, MAXW + 3), ($urandom_range(0, 2) == 0),
                         1'($urandom_range(0, 1)));
        end
        waitEmpty();
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
